// File: rtl/gray_2_bin_tracker_pkg.sv
// Shared types and helpers for the Gray-to-binary tracker: FSM encoding and
// the Hamming-weight function used to classify transitions.
package gray_2_bin_tracker_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_ERR_W = 8;

  // Callers zero-extend narrower vectors; the extra zero bits add nothing.
  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_2_bin_tracker_if.sv
// Sample/result bundle between the Gray producer side and the tracker.
// Handshake: g_valid qualifies g for one cycle with no back-pressure; b_valid
// is a one-cycle pulse marking b/delta/step_err as freshly updated.
interface gray_2_bin_tracker_if
  import gray_2_bin_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ERR_W = DEF_ERR_W
);
  logic             g_valid;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic [WIDTH-1:0] delta;
  logic             step_err;
  logic [ERR_W-1:0] err_count;
  state_t           state;

  modport master (
    output g_valid, g,
    input  b, b_valid, delta, step_err, err_count, state
  );

  modport slave (
    input  g_valid, g,
    output b, b_valid, delta, step_err, err_count, state
  );
endinterface

// File: rtl/gray_2_bin_comb.sv
// Purely combinational Gray-to-binary decode: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_2_bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_2_bin_tracker.sv
// Decodes a sampled Gray count, registers it, reports the modular step from
// the previous sample and counts illegal (multi-bit) Gray transitions.
module gray_2_bin_tracker
  import gray_2_bin_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ERR_W = DEF_ERR_W
) (
  input logic clk,
  input logic rst,
  gray_2_bin_tracker_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d, b_new;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             bv_q, bv_d;
  logic             err_q, err_d;
  int unsigned      hamming;

  gray_2_bin_comb #(.WIDTH(WIDTH)) u_decode (
    .g (bus.g),
    .b (b_new)
  );

  assign hamming = popcount32(32'(bus.g ^ prev_g_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // TRACK is absorbing; only reset returns to EMPTY.
  always_comb begin
    state_d = state_q;
    if (bus.g_valid) state_d = ST_TRACK;
  end

  // b_q doubles as the previous binary value, so no second decoder is needed.
  always_comb begin
    b_d      = b_q;
    delta_d  = delta_q;
    prev_g_d = prev_g_q;
    cnt_d    = cnt_q;
    bv_d     = 1'b0;
    err_d    = 1'b0;
    if (bus.g_valid) begin
      b_d      = b_new;
      bv_d     = 1'b1;
      prev_g_d = bus.g;
      if (state_q == ST_TRACK) begin
        delta_d = b_new - b_q;
        if (hamming >= 2) begin
          err_d = 1'b1;
          if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
      end else begin
        delta_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q      <= '0;
      delta_q  <= '0;
      prev_g_q <= '0;
      cnt_q    <= '0;
      bv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      b_q      <= b_d;
      delta_q  <= delta_d;
      prev_g_q <= prev_g_d;
      cnt_q    <= cnt_d;
      bv_q     <= bv_d;
      err_q    <= err_d;
    end
  end

  assign bus.b         = b_q;
  assign bus.b_valid   = bv_q;
  assign bus.delta     = delta_q;
  assign bus.step_err  = err_q;
  assign bus.err_count = cnt_q;
  assign bus.state     = state_q;

endmodule
